// File: rtl/gpio_bank_if.sv
// gpio_bank_if: register bus between a host and gpio_bank
interface gpio_bank_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        ack;
  logic        resp;
  logic [31:0] rdata;
  modport master (output req, we, addr, be, wdata, input ack, resp, rdata);
  modport slave (input req, we, addr, be, wdata, output ack, resp, rdata);
endinterface

// File: rtl/gpio_bank.sv
// gpio_bank: memory-mapped GPIO bank with set/clear/toggle outputs, direction and edge-capture interrupt
module gpio_bank #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  gpio_bank_if.slave       bus,
  input  logic [WIDTH-1:0] gpio_bi,
  output logic [WIDTH-1:0] gpio_bo,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq_o
);
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] out_q, dir_q, rise_en_q, fall_en_q, status_q, prev_q;
  logic [WIDTH-1:0] in_w, bm, m, ev, rd_w;
  logic [31:0] wmask, wm;
  logic [3:0] off;
  logic [2:0] cnt_q;
  logic wr, rd, unused;
  assign off = bus.addr[5:2];
  assign wr = bus.req & bus.we;
  assign rd = bus.req & ~bus.we;
  assign wmask = {{8{bus.be[3]}}, {8{bus.be[2]}}, {8{bus.be[1]}}, {8{bus.be[0]}}};
  assign wm = bus.wdata & wmask;
  assign bm = wmask[WIDTH-1:0];
  assign m = wm[WIDTH-1:0];
  assign in_w = sync_q[SYNC_STAGES-1];
  assign ev = cnt_q == 3'd0 ? (in_w & ~prev_q & rise_en_q) | (~in_w & prev_q & fall_en_q) : '0;
  assign bus.ack = bus.req;
  assign gpio_bo = out_q;
  assign gpio_oe = dir_q;
  assign irq_o = |status_q;
  assign unused = ^{bus.addr[31:6], bus.addr[1:0], wm, wmask};
  // read view of the addressed register; write-only and unmapped offsets read zero
  always_comb begin
    case (off)
      4'd0:    rd_w = in_w;
      4'd1:    rd_w = out_q;
      4'd5:    rd_w = dir_q;
      4'd6:    rd_w = rise_en_q;
      4'd7:    rd_w = fall_en_q;
      4'd8:    rd_w = status_q;
      default: rd_w = '0;
    endcase
  end
  // pin synchroniser, edge history and startup blanking counter
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
      prev_q <= '0;
      cnt_q  <= 3'(SYNC_STAGES + 1);
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_bi};
      prev_q <= in_w;
      cnt_q  <= cnt_q - 3'(cnt_q != 3'd0);
    end
  end
  // one-cycle read response carrying the pre-edge register value
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bus.resp  <= 1'b0;
      bus.rdata <= '0;
    end else begin
      bus.resp  <= rd;
      bus.rdata <= rd ? 32'(rd_w) : bus.rdata;
    end
  end
  // control registers with byte-lane qualified writes
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_q     <= '0;
      dir_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
    end else begin
      out_q     <= !wr ? out_q :
                   off == 4'd1 ? (out_q & ~bm) | m :
                   off == 4'd2 ? out_q | m :
                   off == 4'd3 ? out_q & ~m :
                   off == 4'd4 ? out_q ^ m : out_q;
      dir_q     <= wr && off == 4'd5 ? (dir_q & ~bm) | m : dir_q;
      rise_en_q <= wr && off == 4'd6 ? (rise_en_q & ~bm) | m : rise_en_q;
      fall_en_q <= wr && off == 4'd7 ? (fall_en_q & ~bm) | m : fall_en_q;
    end
  end
  // sticky edge status, write-one-to-clear, a same-cycle event beats the clear
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) status_q <= '0;
    else status_q <= (status_q & ~(wr && off == 4'd8 ? m : '0)) | ev;
  end
endmodule
